mc_ctrl: RTL and testbench

Multi-cycle sequencing controller for the RV32I subset datapath (R-type ALU, I-type ALU and shifts, lui, lw, sw, beq, jal). It replaces single-cycle control so that one ALU and one unified instruction/data memory port can be reused across cycles. Each instruction is stepped through fetch, decode, execute, memory and writeback states, with memory stalls honoured. It emits the existing control encodings from ctrl_encode_def.v (ALUOp, EXTOp, NPCOp, WDSel).

---
 rtl/mc_ctrl_if.sv | 38 +++
 rtl/mc_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle sequencer (master) and the RV32I datapath (slave).
// The sequencer drives every enable and select; the datapath returns instruction fields and status.
interface mc_ctrl_if;
    logic [6:0] Op;
    logic [6:0] Funct7;
    logic [2:0] Funct3;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [4:0] ALUOp;
    logic [5:0] EXTOp;
    logic [2:0] NPCOp;
    logic [1:0] WDSel;
    logic       retire;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  Op, Funct7, Funct3, Zero, mem_ready,
        output PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, EXTOp, NPCOp, WDSel,
               retire, illegal, state
    );

    modport slave (
        output Op, Funct7, Funct3, Zero, mem_ready,
        input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, EXTOp, NPCOp, WDSel,
               retire, illegal, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer for the RV32I subset datapath sharing one ALU and one memory port.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unsupported instructions instead of retiring them as NOPs.
module mc_ctrl (
    input  logic       clk,
    input  logic       rstn,
    mc_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ADDR   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB_ALU = 4'd6,
        S_WB_MEM = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_TRAP   = 4'd15
    } state_e;

    typedef enum logic [2:0] {
        CL_NONE,
        CL_RTYPE,
        CL_ITYPE,
        CL_LUI,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_JAL
    } class_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [4:0] ALU_NOP  = 5'b00000;
    localparam logic [4:0] ALU_LUI  = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b01010;
    localparam logic [4:0] ALU_SLTU = 5'b01011;
    localparam logic [4:0] ALU_XOR  = 5'b01100;
    localparam logic [4:0] ALU_OR   = 5'b01101;
    localparam logic [4:0] ALU_AND  = 5'b01110;
    localparam logic [4:0] ALU_SLL  = 5'b01111;
    localparam logic [4:0] ALU_SRL  = 5'b10000;
    localparam logic [4:0] ALU_SRA  = 5'b10001;

    localparam logic [5:0] EXT_NONE   = 6'b000000;
    localparam logic [5:0] EXT_ISHAMT = 6'b100000;
    localparam logic [5:0] EXT_ITYPE  = 6'b010000;
    localparam logic [5:0] EXT_STYPE  = 6'b001000;
    localparam logic [5:0] EXT_BTYPE  = 6'b000100;
    localparam logic [5:0] EXT_UTYPE  = 6'b000010;
    localparam logic [5:0] EXT_JTYPE  = 6'b000001;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;

    state_e     state_q, state_d;
    class_e     cls_q, cls_d;
    logic [4:0] alu_op_q, alu_op_d;
    logic [5:0] ext_op_q, ext_op_d;

    class_e     dec_cls;
    logic [4:0] dec_alu;
    logic [5:0] dec_ext;

    // Combinational decode of the IR fields; only sampled while in DECODE.
    always_comb begin
        dec_cls = CL_NONE;
        dec_alu = ALU_NOP;
        dec_ext = EXT_NONE;
        case (bus.Op)
            OP_RTYPE: begin
                case (bus.Funct3)
                    3'b000:  dec_alu = (bus.Funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    3'b001:  dec_alu = ALU_SLL;
                    3'b010:  dec_alu = ALU_SLT;
                    3'b011:  dec_alu = ALU_SLTU;
                    3'b100:  dec_alu = ALU_XOR;
                    3'b101:  dec_alu = (bus.Funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    3'b110:  dec_alu = ALU_OR;
                    default: dec_alu = ALU_AND;
                endcase
                if (bus.Funct7 == F7_BASE ||
                    (bus.Funct7 == F7_ALT && (bus.Funct3 == 3'b000 || bus.Funct3 == 3'b101))) begin
                    dec_cls = CL_RTYPE;
                end
            end
            OP_ITYPE: begin
                dec_ext = EXT_ITYPE;
                dec_cls = CL_ITYPE;
                case (bus.Funct3)
                    3'b000:  dec_alu = ALU_ADD;
                    3'b010:  dec_alu = ALU_SLT;
                    3'b011:  dec_alu = ALU_SLTU;
                    3'b100:  dec_alu = ALU_XOR;
                    3'b110:  dec_alu = ALU_OR;
                    3'b111:  dec_alu = ALU_AND;
                    3'b001: begin
                        dec_alu = ALU_SLL;
                        dec_ext = EXT_ISHAMT;
                        if (bus.Funct7 != F7_BASE) dec_cls = CL_NONE;
                    end
                    default: begin
                        dec_alu = (bus.Funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        dec_ext = EXT_ISHAMT;
                        if (bus.Funct7 != F7_BASE && bus.Funct7 != F7_ALT) dec_cls = CL_NONE;
                    end
                endcase
            end
            OP_LUI: begin
                dec_cls = CL_LUI;
                dec_alu = ALU_LUI;
                dec_ext = EXT_UTYPE;
            end
            OP_LOAD: begin
                dec_alu = ALU_ADD;
                dec_ext = EXT_ITYPE;
                if (bus.Funct3 == 3'b010) dec_cls = CL_LW;
            end
            OP_STORE: begin
                dec_alu = ALU_ADD;
                dec_ext = EXT_STYPE;
                if (bus.Funct3 == 3'b010) dec_cls = CL_SW;
            end
            OP_BRANCH: begin
                dec_alu = ALU_SUB;
                dec_ext = EXT_BTYPE;
                if (bus.Funct3 == 3'b000) dec_cls = CL_BEQ;
            end
            OP_JAL: begin
                dec_cls = CL_JAL;
                dec_ext = EXT_JTYPE;
            end
            default: ;
        endcase
        if (dec_cls == CL_NONE) begin
            dec_alu = ALU_NOP;
            dec_ext = EXT_NONE;
        end
    end

    // Class and operation selects are frozen at DECODE so later states see stable encodings.
    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        alu_op_d = alu_op_q;
        ext_op_d = ext_op_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                cls_d    = dec_cls;
                alu_op_d = dec_alu;
                ext_op_d = dec_ext;
                case (dec_cls)
                    CL_RTYPE, CL_ITYPE, CL_LUI: state_d = S_EXEC;
                    CL_LW, CL_SW:               state_d = S_ADDR;
                    CL_BEQ:                     state_d = S_BRANCH;
                    CL_JAL:                     state_d = S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:                    state_d = S_TRAP;
`else
                    default:                    state_d = S_FETCH;
`endif
                endcase
            end
            S_EXEC:   state_d = S_WB_ALU;
            S_WB_ALU: state_d = S_FETCH;
            S_ADDR:   state_d = (cls_q == CL_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (bus.mem_ready) state_d = S_WB_MEM;
            S_WB_MEM: state_d = S_FETCH;
            S_MEM_WR: if (bus.mem_ready) state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_FETCH;
            cls_q    <= CL_NONE;
            alu_op_q <= ALU_NOP;
            ext_op_q <= EXT_NONE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cls_q    <= cls_d;
            alu_op_q <= alu_op_d;
            ext_op_q <= ext_op_d;
        end
    end

    // Outputs decode the state register; gating with rstn keeps everything low during reset.
    always_comb begin
        // NOTE: every output is defaulted first so no path through the case infers a latch.
        bus.PCWrite  = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUSrcA  = 2'd0;
        bus.ALUSrcB  = 2'd0;
        bus.ALUOp    = ALU_NOP;
        bus.EXTOp    = EXT_NONE;
        bus.NPCOp    = NPC_PLUS4;
        bus.WDSel    = 2'b00;
        bus.retire   = 1'b0;
        bus.illegal  = 1'b0;
        if (rstn) begin
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.NPCOp   = NPC_PLUS4;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                end
                S_DECODE: begin
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
                    bus.retire = (dec_cls == CL_NONE);
`endif
                end
                S_EXEC: begin
                    bus.ALUSrcA = 2'd0;
                    bus.ALUSrcB = (cls_q == CL_RTYPE) ? 2'd0 : 2'd1;
                    bus.ALUOp   = alu_op_q;
                    bus.EXTOp   = ext_op_q;
                end
                S_WB_ALU: begin
                    bus.RegWrite = 1'b1;
                    bus.WDSel    = 2'b00;
                    bus.retire   = 1'b1;
                end
                S_ADDR: begin
                    bus.ALUSrcB = 2'd1;
                    bus.ALUOp   = alu_op_q;
                    bus.EXTOp   = ext_op_q;
                end
                S_MEM_RD: bus.MemRead = 1'b1;
                S_WB_MEM: begin
                    bus.RegWrite = 1'b1;
                    bus.WDSel    = 2'b01;
                    bus.retire   = 1'b1;
                end
                S_MEM_WR: begin
                    bus.MemWrite = 1'b1;
                    bus.retire   = bus.mem_ready;
                end
                S_BRANCH: begin
                    bus.ALUOp   = alu_op_q;
                    bus.EXTOp   = ext_op_q;
                    bus.NPCOp   = NPC_BRANCH;
                    bus.PCWrite = bus.Zero;
                    bus.retire  = 1'b1;
                end
                S_JUMP: begin
                    bus.EXTOp    = ext_op_q;
                    bus.NPCOp    = NPC_JUMP;
                    bus.PCWrite  = 1'b1;
                    bus.RegWrite = 1'b1;
                    bus.WDSel    = 2'b10;
                    bus.retire   = 1'b1;
                end
                S_TRAP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    bus.illegal = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: a per-instruction vector table plus hand-written
// sequences for reset, memory wait states, reset during a store and unsupported opcodes.
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic rstn;

    mc_ctrl_if bus();

    mc_ctrl u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.EXTOp, bus.NPCOp, bus.WDSel,
                bus.retire, bus.illegal, bus.state};
    endfunction

    typedef struct packed {
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       zero;
        logic [3:0] cyc;    // cycles from FETCH to the retire cycle inclusive
        logic [3:0] work;   // state whose ALU/EXT selects are checked
        logic [3:0] last;   // state in the retire cycle
        logic [4:0] alu;
        logic [5:0] ext;
        logic [1:0] srcb;
        logic [1:0] wdsel;
        logic       rw;
        logic       pcw;
        logic [2:0] npc;
        logic       mw;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic run_vec(input int idx, input vec_t v);
        int          cycles = 0;
        bit          done = 1'b0;
        int          rw_n = 0;
        int          mw_n = 0;
        int          excl = 0;
        logic [31:0] alu = 32'hdead;
        logic [31:0] ext = 32'hdead;
        logic [31:0] srcb = 32'hdead;
        logic [31:0] last = 32'hdead;
        logic [31:0] wds = 32'hdead;
        logic [31:0] rwr = 32'hdead;
        logic [31:0] pcw = 32'hdead;
        logic [31:0] npc = 32'hdead;
        bus.Op = v.op;
        bus.Funct7 = v.f7;
        bus.Funct3 = v.f3;
        bus.Zero = v.zero;
        bus.mem_ready = 1'b1;
        while (!done && cycles < 16) begin
            @(negedge clk);
            cycles++;
            if (bus.state == v.work) begin
                alu  = 32'(bus.ALUOp);
                ext  = 32'(bus.EXTOp);
                srcb = 32'(bus.ALUSrcB);
            end
            if (bus.RegWrite) rw_n++;
            if (bus.MemWrite) mw_n++;
            if (bus.state != 4'd0 && $countones({bus.PCWrite, bus.IRWrite, bus.MemWrite}) > 1) excl++;
            if (bus.retire) begin
                done = 1'b1;
                last = 32'(bus.state);
                wds  = 32'(bus.WDSel);
                rwr  = 32'(bus.RegWrite);
                pcw  = 32'(bus.PCWrite);
                npc  = 32'(bus.NPCOp);
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("v%0d_cycles", idx), 32'(cycles), 32'(v.cyc));
        check($sformatf("v%0d_last_state", idx), last, 32'(v.last));
        check($sformatf("v%0d_aluop", idx), alu, 32'(v.alu));
        check($sformatf("v%0d_extop", idx), ext, 32'(v.ext));
        check($sformatf("v%0d_alusrcb", idx), srcb, 32'(v.srcb));
        check($sformatf("v%0d_wdsel", idx), wds, 32'(v.wdsel));
        check($sformatf("v%0d_regwrite_at_retire", idx), rwr, 32'(v.rw));
        check($sformatf("v%0d_pcwrite_at_retire", idx), pcw, 32'(v.pcw));
        check($sformatf("v%0d_npcop", idx), npc, 32'(v.npc));
        check($sformatf("v%0d_regwrite_cycles", idx), 32'(rw_n), 32'(v.rw));
        check($sformatf("v%0d_memwrite_cycles", idx), 32'(mw_n), 32'(v.mw));
        check($sformatf("v%0d_write_exclusive", idx), 32'(excl), 32'd0);
        check($sformatf("v%0d_back_in_fetch", idx), 32'(bus.state), 32'd0);
    endtask

    // Trace results of the hand-written multi-cycle sequences.
    logic [31:0] tr_word;
    int          tr_len, rd_cnt, wr_cnt, rw_cnt, ret_cnt, pcw_cnt, mw_any;
    logic [1:0]  wdsel_last;

    task automatic run_trace(input logic [6:0] op, input logic [2:0] f3,
                             input int fetch_waits, input int mem_waits);
        int fw = 0;
        int mwc = 0;
        bit done = 1'b0;
        tr_word = '0;
        tr_len = 0; rd_cnt = 0; wr_cnt = 0; rw_cnt = 0; ret_cnt = 0; pcw_cnt = 0; mw_any = 0;
        wdsel_last = 2'b11;
        bus.Op = op;
        bus.Funct7 = 7'd0;
        bus.Funct3 = f3;
        bus.Zero = 1'b0;
        while (!done && tr_len < 16) begin
            if (bus.state == 4'd0 && fw < fetch_waits) begin
                bus.mem_ready = 1'b0;
                fw++;
            end else if ((bus.state == 4'd4 || bus.state == 4'd5) && mwc < mem_waits) begin
                bus.mem_ready = 1'b0;
                mwc++;
            end else begin
                bus.mem_ready = 1'b1;
            end
            @(negedge clk);
            tr_word = {tr_word[27:0], bus.state};
            tr_len++;
            if (bus.state == 4'd4 && bus.MemRead) rd_cnt++;
            if (bus.state == 4'd5 && bus.MemWrite) wr_cnt++;
            if (bus.MemWrite) mw_any++;
            if (bus.RegWrite) rw_cnt++;
            if (bus.PCWrite && bus.state != 4'd0) pcw_cnt++;
            if (bus.retire) begin
                ret_cnt++;
                done = 1'b1;
                wdsel_last = bus.WDSel;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vecs[0]  = '{7'b0110011, 7'b0000000, 3'b000, 1'b0, 4'd4, 4'd2, 4'd6, 5'b00011, 6'b000000, 2'd0, 2'b00, 1'b1, 1'b0, 3'b000, 1'b0}; // add
        vecs[1]  = '{7'b0110011, 7'b0100000, 3'b000, 1'b0, 4'd4, 4'd2, 4'd6, 5'b00100, 6'b000000, 2'd0, 2'b00, 1'b1, 1'b0, 3'b000, 1'b0}; // sub
        vecs[2]  = '{7'b0110011, 7'b0100000, 3'b101, 1'b0, 4'd4, 4'd2, 4'd6, 5'b10001, 6'b000000, 2'd0, 2'b00, 1'b1, 1'b0, 3'b000, 1'b0}; // sra
        vecs[3]  = '{7'b0110011, 7'b0000000, 3'b011, 1'b0, 4'd4, 4'd2, 4'd6, 5'b01011, 6'b000000, 2'd0, 2'b00, 1'b1, 1'b0, 3'b000, 1'b0}; // sltu
        vecs[4]  = '{7'b0010011, 7'b0000011, 3'b000, 1'b0, 4'd4, 4'd2, 4'd6, 5'b00011, 6'b010000, 2'd1, 2'b00, 1'b1, 1'b0, 3'b000, 1'b0}; // addi
        vecs[5]  = '{7'b0010011, 7'b0100000, 3'b101, 1'b0, 4'd4, 4'd2, 4'd6, 5'b10001, 6'b100000, 2'd1, 2'b00, 1'b1, 1'b0, 3'b000, 1'b0}; // srai
        vecs[6]  = '{7'b0010011, 7'b0000000, 3'b001, 1'b0, 4'd4, 4'd2, 4'd6, 5'b01111, 6'b100000, 2'd1, 2'b00, 1'b1, 1'b0, 3'b000, 1'b0}; // slli
        vecs[7]  = '{7'b0010011, 7'b1111111, 3'b111, 1'b0, 4'd4, 4'd2, 4'd6, 5'b01110, 6'b010000, 2'd1, 2'b00, 1'b1, 1'b0, 3'b000, 1'b0}; // andi
        vecs[8]  = '{7'b0110111, 7'b1010101, 3'b110, 1'b0, 4'd4, 4'd2, 4'd6, 5'b00001, 6'b000010, 2'd1, 2'b00, 1'b1, 1'b0, 3'b000, 1'b0}; // lui
        vecs[9]  = '{7'b0000011, 7'b0000000, 3'b010, 1'b0, 4'd5, 4'd3, 4'd7, 5'b00011, 6'b010000, 2'd1, 2'b01, 1'b1, 1'b0, 3'b000, 1'b0}; // lw
        vecs[10] = '{7'b0100011, 7'b0000000, 3'b010, 1'b0, 4'd4, 4'd3, 4'd5, 5'b00011, 6'b001000, 2'd1, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1}; // sw
        vecs[11] = '{7'b1100011, 7'b0000000, 3'b000, 1'b1, 4'd3, 4'd8, 4'd8, 5'b00100, 6'b000100, 2'd0, 2'b00, 1'b0, 1'b1, 3'b001, 1'b0}; // beq taken
        vecs[12] = '{7'b1100011, 7'b0000000, 3'b000, 1'b0, 4'd3, 4'd8, 4'd8, 5'b00100, 6'b000100, 2'd0, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0}; // beq not taken
        vecs[13] = '{7'b1101111, 7'b0000000, 3'b000, 1'b0, 4'd3, 4'd9, 4'd9, 5'b00000, 6'b000001, 2'd0, 2'b10, 1'b1, 1'b1, 3'b010, 1'b0}; // jal

        rstn = 1'b0;
        bus.Op = 7'b0110011;
        bus.Funct7 = 7'd0;
        bus.Funct3 = 3'd0;
        bus.Zero = 1'b1;
        bus.mem_ready = 1'b1;

        repeat (3) begin
            @(negedge clk);
            check("reset_outputs_zero", all_outs(), 32'd0);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        check("release_state", 32'(bus.state), 32'd0);
        check("release_memread", 32'(bus.MemRead), 32'd1);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // lw with two wait cycles in MEM_RD.
        run_trace(7'b0000011, 3'b010, 0, 2);
        check("lw_wait_trace", tr_word, 32'h0134447);
        check("lw_wait_len", 32'(tr_len), 32'd7);
        check("lw_wait_memread_cycles", 32'(rd_cnt), 32'd3);
        check("lw_wait_wdsel", 32'(wdsel_last), 32'd1);
        check("lw_wait_regwrite_cycles", 32'(rw_cnt), 32'd1);

        // sw with one FETCH wait and two MEM_WR waits.
        run_trace(7'b0100011, 3'b010, 1, 2);
        check("sw_wait_trace", tr_word, 32'h0013555);
        check("sw_wait_memwrite_cycles", 32'(wr_cnt), 32'd3);
        check("sw_wait_retires", 32'(ret_cnt), 32'd1);
        check("sw_wait_regwrite_cycles", 32'(rw_cnt), 32'd0);

        // Reset while a store is pending in MEM_WR.
        bus.Op = 7'b0100011;
        bus.Funct3 = 3'b010;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 10 && bus.state != 4'd5; i++) begin
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b0;
        #1;
        check("pending_sw_state", 32'(bus.state), 32'd5);
        check("pending_sw_memwrite", 32'(bus.MemWrite), 32'd1);
        rstn = 1'b0;
        #1;
        check("reset_mid_sw_outputs", all_outs(), 32'd0);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("reset_mid_sw_held", all_outs(), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        check("rerelease_memread", 32'(bus.MemRead), 32'd1);

        // Unsupported opcode.
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        bus.Op = 7'b1110011;
        bus.mem_ready = 1'b1;
        ret_cnt = 0;
        rw_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.retire) ret_cnt++;
            if (bus.RegWrite || bus.MemWrite) rw_cnt++;
            @(posedge clk);
            #1;
        end
        check("trap_state", 32'(bus.state), 32'd15);
        check("trap_illegal", 32'(bus.illegal), 32'd1);
        check("trap_no_retire", 32'(ret_cnt), 32'd0);
        check("trap_no_writes", 32'(rw_cnt), 32'd0);
`else
        run_trace(7'b1110011, 3'b000, 0, 0);
        check("nop_trace", tr_word, 32'h01);
        check("nop_len", 32'(tr_len), 32'd2);
        check("nop_retires", 32'(ret_cnt), 32'd1);
        check("nop_no_regwrite", 32'(rw_cnt), 32'd0);
        check("nop_no_memwrite", 32'(mw_any), 32'd0);
        check("nop_no_pcwrite", 32'(pcw_cnt), 32'd0);
        check("nop_back_in_fetch", 32'(bus.state), 32'd0);
        check("nop_illegal_low", 32'(bus.illegal), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
